// File: rtl/writeback_queue.sv
// writeback_queue: buffers completed ALU/load results in a small FIFO and
// drains one per cycle into the register bank write port. It also reports
// whether a source register still has a write in flight.
// Optional feature macro: WBQ_FORWARDING_EN. When defined, fwd1/fwd2 carry
// the newest pending value. When undefined, they are tied to zero and only
// hit1/hit2 are produced.
module writeback_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        q_addr1,
  input  logic [ADDR_W-1:0]        q_addr2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        fwd1,
  output logic [DATA_W-1:0]        fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_enq;
  logic w_hit1;
  logic w_hit2;

  // Ready depends on registered occupancy only, so a same-edge pop never frees a slot early
  assign in_ready = !rst && (r_count < CNT_W'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !wr_stall && (r_count != '0);
  assign w_bypass = !wr_stall && (r_count == '0) && w_push;
  assign w_enq    = w_push && !w_bypass;

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign count   = r_count;
  assign hit1    = w_hit1;
  assign hit2    = w_hit2;

  // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; validity is tracked by head/count, so the payload needs no reset
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_addr[r_tail] <= in_rd;
      r_mem_data[r_tail] <= in_data;
    end
  end

  // Bank write register: pop the head, or bypass straight from the input when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (wr_stall) begin
      r_wr_en <= 1'b0;
    end else if (w_pop) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= r_mem_addr[r_head];
      r_wr_data <= r_mem_data[r_head];
    end else if (w_bypass) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= in_rd;
      r_wr_data <= in_data;
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  // Pending-write detection against the output register and all valid entries
  always_ff @(posedge clk or posedge rst) begin : unused_guard
    if (rst) begin
    end
  end

  always_comb begin
    w_hit1 = r_wr_en && (r_wr_addr == q_addr1);
    w_hit2 = r_wr_en && (r_wr_addr == q_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count) begin
        if (r_mem_addr[r_head + PTR_W'(i)] == q_addr1) w_hit1 = 1'b1;
        if (r_mem_addr[r_head + PTR_W'(i)] == q_addr2) w_hit2 = 1'b1;
      end
    end
  end

`ifdef WBQ_FORWARDING_EN
  logic [DATA_W-1:0] w_fwd1;
  logic [DATA_W-1:0] w_fwd2;

  // Newest match wins: scan output register, then entries oldest to newest
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    if (r_wr_en && (r_wr_addr == q_addr1)) w_fwd1 = r_wr_data;
    if (r_wr_en && (r_wr_addr == q_addr2)) w_fwd2 = r_wr_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count) begin
        if (r_mem_addr[r_head + PTR_W'(i)] == q_addr1) w_fwd1 = r_mem_data[r_head + PTR_W'(i)];
        if (r_mem_addr[r_head + PTR_W'(i)] == q_addr2) w_fwd2 = r_mem_data[r_head + PTR_W'(i)];
      end
    end
  end

  assign fwd1 = w_fwd1;
  assign fwd2 = w_fwd2;
`else
  // Decode stalls on any hit, so no data path is needed
  assign fwd1 = '0;
  assign fwd2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_writeback_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 4;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_rd;
  logic [DATA_W-1:0]      in_data;
  logic                   wr_stall;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [ADDR_W-1:0]      q_addr1;
  logic [ADDR_W-1:0]      q_addr2;
  logic                   hit1;
  logic                   hit2;
  logic [DATA_W-1:0]      fwd1;
  logic [DATA_W-1:0]      fwd2;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: pending results in arrival order plus the bank write register
  ent_t              mq[$];
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Newest pending write to a register: later queue entries override older ones
  task automatic lookup(input logic [ADDR_W-1:0] a, output logic h, output logic [DATA_W-1:0] f);
    h = 1'b0;
    f = '0;
    if (m_en && m_addr == a) begin
      h = 1'b1;
      f = m_data;
    end
    foreach (mq[i]) begin
      if (mq[i].rd == a) begin
        h = 1'b1;
        f = mq[i].data;
      end
    end
`ifndef WBQ_FORWARDING_EN
    f = '0;
`endif
  endtask

  task automatic check_all();
    logic              h1, h2;
    logic [DATA_W-1:0] f1, f2;
    lookup(q_addr1, h1, f1);
    lookup(q_addr2, h2, f2);
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check("wr_en",    64'(wr_en),    64'(m_en));
    check("wr_addr",  64'(wr_addr),  64'(m_addr));
    check("wr_data",  64'(wr_data),  64'(m_data));
    check("count",    64'(count),    64'(mq.size()));
    check("hit1",     64'(hit1),     64'(h1));
    check("hit2",     64'(hit2),     64'(h2));
    check("fwd1",     64'(fwd1),     64'(f1));
    check("fwd2",     64'(fwd2),     64'(f2));
  endtask

  // Apply one clock edge of the specification's rules to the model
  task automatic model_edge();
    logic push;
    ent_t e, h;
    push   = in_valid && (mq.size() < DEPTH);
    e.rd   = in_rd;
    e.data = in_data;
    if (wr_stall) begin
      m_en = 1'b0;
      if (push) mq.push_back(e);
    end else if (mq.size() > 0) begin
      h      = mq.pop_front();
      m_en   = 1'b1;
      m_addr = h.rd;
      m_data = h.data;
      if (push) mq.push_back(e);
    end else if (push) begin
      m_en   = 1'b1;
      m_addr = e.rd;
      m_data = e.data;
    end else begin
      m_en = 1'b0;
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic step(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                      input logic st, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    @(negedge clk);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wr_stall = st;
    q_addr1  = a1;
    q_addr2  = a2;
    #1;
    check_all();
    model_edge();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},    64'(wr_en),    64'(0));
    check({tag, "_count"},    64'(count),    64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_hit1"},     64'(hit1),     64'(0));
    check({tag, "_hit2"},     64'(hit2),     64'(0));
    check({tag, "_wr_addr"},  64'(wr_addr),  64'(0));
    check({tag, "_wr_data"},  64'(wr_data),  64'(0));
    check({tag, "_fwd1"},     64'(fwd1),     64'(0));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    wr_stall = 1'b0;
    q_addr1  = '0;
    q_addr2  = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single push into an empty queue: written the cycle after acceptance
    step(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd3, 4'd0);
    step(1'b0, 4'd0, 32'h0,         1'b0, 4'd3, 4'd0);
    step(1'b0, 4'd0, 32'h0,         1'b0, 4'd3, 4'd0);

    // Fill under stall; fifth push must be refused, then drain in order
    for (int i = 1; i <= 5; i++)
      step(1'b1, ADDR_W'(i), DATA_W'(i * 'h11), 1'b1, 4'd1, 4'd4);
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 4'd5);

    // Two writes to the same register: newest value must win
    step(1'b1, 4'd7, 32'h10, 1'b1, 4'd7, 4'd8);
    step(1'b1, 4'd7, 32'h20, 1'b1, 4'd7, 4'd8);
    step(1'b0, 4'd0, 32'h0,  1'b1, 4'd7, 4'd8);
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'd0, 32'h0, 1'b0, 4'd7, 4'd8);

    // Continuous streaming through the empty bypass
    for (int i = 0; i < 8; i++)
      step(1'b1, ADDR_W'(i + 8), DATA_W'(32'h100 + i), 1'b0, ADDR_W'(i + 7), 4'd0);
    step(1'b0, 4'd0, 32'h0, 1'b0, 4'd15, 4'd0);

    // Full queue with a pop in the same cycle: in_ready stays low that cycle
    for (int i = 0; i < 4; i++)
      step(1'b1, ADDR_W'(i), DATA_W'(32'hA0 + i), 1'b1, 4'd0, 4'd3);
    step(1'b1, 4'd12, 32'hC0, 1'b0, 4'd12, 4'd0);
    step(1'b1, 4'd13, 32'hD0, 1'b0, 4'd13, 4'd12);
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'd0, 32'h0, 1'b0, 4'd13, 4'd12);

    // Asynchronous reset mid-cycle with three entries queued and a write presented
    for (int i = 0; i < 4; i++)
      step(1'b1, ADDR_W'(9 + i), DATA_W'(32'h900 + i), 1'b1, 4'd9, 4'd10);
    step(1'b0, 4'd0, 32'h0, 1'b0, 4'd10, 4'd11);
    @(negedge clk);
    in_valid = 1'b0;
    wr_stall = 1'b1;
    q_addr1  = 4'd10;
    q_addr2  = 4'd11;
    #1;
    check_all();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'd0, 32'h0, 1'b0, 4'd10, 4'd11);

    // Randomized traffic with phases of light and heavy back-pressure
    for (int i = 0; i < 600; i++) begin
      int stall_pct;
      stall_pct = ((i / 50) % 2 == 1) ? 70 : 20;
      step($urandom_range(0, 99) < 75,
           ADDR_W'($urandom),
           DATA_W'($urandom),
           $urandom_range(0, 99) < stall_pct,
           ADDR_W'($urandom),
           ADDR_W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
